// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter:
// FSM state encodings, default oversampling ratio and divisor width.
package uart_pkg;

  localparam int DIV_W              = 16;
  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: one-clk tick every divisor+1 clocks. A synchronous
// clear reloads the counter so the first tick lands divisor+1 clocks later.
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || cnt_reg == '0) begin
      cnt_reg <= divisor;
    end else begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign tick = ~clr & (cnt_reg == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, mid-bit sampling, LSB first.
// Define UART_RX_PARITY_EN to add one parity bit (even/odd via parity_odd).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     divisor,
  input  logic                 rx_en,
  input  logic                 serial_in,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] para_data_out,
  output logic                 rx_flag,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] SAMPLE_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);

  uart_state_t            state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   line_prev_reg;
  logic [DIV_W-1:0]       div_latched_reg, div_sel;
  logic [SW-1:0]          scnt_reg, scnt_next;
  logic [BW-1:0]          bcnt_reg, bcnt_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic [DATA_BITS-1:0]   data_reg, data_next;
  logic                   rx_flag_reg, rx_flag_next;
  logic                   frame_err_reg, frame_err_next;
  logic                   start_det, tick, line;

  assign line = sync_reg[SYNC_STAGES-1];

  // The divisor is captured at start detection; the tick generator sees the
  // live value only on that cycle so mid-frame changes wait for the next frame.
  assign div_sel = start_det ? divisor : div_latched_reg;

  uart_baud_tick u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start_det | ~rx_en),
    .divisor (div_sel),
    .tick    (tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad_reg, par_bad_next;
  logic parity_err_reg, parity_err_next;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      sync_reg        <= '1;
      line_prev_reg   <= 1'b1;
      div_latched_reg <= '0;
      scnt_reg        <= '0;
      bcnt_reg        <= '0;
      shift_reg       <= '0;
      data_reg        <= '0;
      rx_flag_reg     <= 1'b0;
      frame_err_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg     <= 1'b0;
      parity_err_reg  <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      sync_reg        <= {sync_reg[SYNC_STAGES-2:0], serial_in};
      line_prev_reg   <= line;
      if (start_det) div_latched_reg <= divisor;
      scnt_reg        <= scnt_next;
      bcnt_reg        <= bcnt_next;
      shift_reg       <= shift_next;
      data_reg        <= data_next;
      rx_flag_reg     <= rx_flag_next;
      frame_err_reg   <= frame_err_next;
`ifdef UART_RX_PARITY_EN
      par_bad_reg     <= par_bad_next;
      parity_err_reg  <= parity_err_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    scnt_next      = scnt_reg;
    bcnt_next      = bcnt_reg;
    shift_next     = shift_reg;
    data_next      = data_reg;
    rx_flag_next   = 1'b0;
    frame_err_next = 1'b0;
    start_det      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next    = par_bad_reg;
    parity_err_next = 1'b0;
`endif
    if (!rx_en) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (line_prev_reg && !line) begin
            start_det  = 1'b1;
            scnt_next  = '0;
            state_next = ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (scnt_reg == SAMPLE_MID) begin
              // A line that is high again at mid-start was only a glitch.
              scnt_next  = '0;
              bcnt_next  = '0;
              state_next = line ? ST_IDLE : ST_DATA;
            end else begin
              scnt_next = scnt_reg + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (scnt_reg == SAMPLE_LAST) begin
              scnt_next  = '0;
              shift_next = {line, shift_reg[DATA_BITS-1:1]};
              if (bcnt_reg == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_next = ST_PARITY;
`else
                state_next = ST_STOP;
`endif
              end else begin
                bcnt_next = bcnt_reg + 1'b1;
              end
            end else begin
              scnt_next = scnt_reg + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            if (scnt_reg == SAMPLE_LAST) begin
              scnt_next    = '0;
              par_bad_next = line ^ (^shift_reg) ^ parity_odd;
              state_next   = ST_STOP;
            end else begin
              scnt_next = scnt_reg + 1'b1;
            end
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (scnt_reg == SAMPLE_LAST) begin
              scnt_next  = '0;
              state_next = ST_IDLE;
              if (!line) begin
                frame_err_next = 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (par_bad_reg) begin
                parity_err_next = 1'b1;
`endif
              end else begin
                rx_flag_next = 1'b1;
                data_next    = shift_reg;
              end
            end else begin
              scnt_next = scnt_reg + 1'b1;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign para_data_out = data_reg;
  assign rx_flag       = rx_flag_reg;
  assign frame_err     = frame_err_reg;
  assign rx_busy       = (state_reg != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err    = parity_err_reg;
`else
  assign parity_err    = 1'b0;
`endif

endmodule
